// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage feeding the control unit. Holds the PC, computes
//   the next PC when the control unit requests an advance, fetches the word
//   from instruction memory, and presents it with a one-cycle strobe.
//
// Handshake: IMEM_REQ is held high with IMEM_ADDR stable until IMEM_VALID is
//   seen high on a rising CLK edge. IMEM_VALID is ignored while IMEM_REQ=0.
//   INST_ENB is a single-cycle strobe that qualifies MEM_INST/PC_ADDR.
//
// Ports
//   CLK, RST_DONE             clock, async active-high reset
//   PC_CLK                    async advance request level (synchronised here)
//   PC_MUX_SELECT, BR_TAKEN   next-PC selection
//   IMM, ALU_RESULT           PC-relative offset / absolute JALR target
//   IMEM_ADDR/REQ/RDATA/VALID instruction memory request/response
//   MEM_INST, INST_ENB        fetched instruction and its strobe
//   PC_ADDR, PC_PLUS4         address of MEM_INST and its link value
//   FETCH_ERR                 sticky fault (misaligned target or timeout)
//   STATE_DBG                 current FSM state, for observation only
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST_DONE,
    input  logic        PC_CLK,
    input  logic [2:0]  PC_MUX_SELECT,
    input  logic        BR_TAKEN,
    input  logic [31:0] IMM,
    input  logic [31:0] ALU_RESULT,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_REQ,
    input  logic [31:0] IMEM_RDATA,
    input  logic        IMEM_VALID,
    output logic [31:0] MEM_INST,
    output logic        INST_ENB,
    output logic [31:0] PC_ADDR,
    output logic [31:0] PC_PLUS4,
    output logic        FETCH_ERR,
    output logic [2:0]  STATE_DBG
);

    localparam logic [2:0] ST_BOOT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_REQ   = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   NOP       = 32'h0000_0013;

    logic [2:0]    state_q,    state_d;
    logic [31:0]   pc_q,       pc_d;
    logic [31:0]   pc_addr_q,  pc_addr_d;
    logic [31:0]   mem_inst_q, mem_inst_d;
    logic          err_q,      err_d;
    logic          pend_q,     pend_d;
    logic [CW-1:0] wait_q,     wait_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [2:0]    prime_q;
    logic          pc_edge;
    logic [31:0]   next_pc;

    // prime_q fills with ones once prev_q holds a genuine post-reset sample,
    // so a PC_CLK level already high at reset release never reads as an edge.
    always_ff @(posedge CLK or posedge RST_DONE) begin
        if (RST_DONE) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            prime_q <= 3'b000;
        end else begin
            sync1_q <= PC_CLK;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            prime_q <= {prime_q[1:0], 1'b1};
        end
    end

    assign pc_edge = sync2_q & ~prev_q & prime_q[2];

    always_comb begin
        next_pc = pc_addr_q + 32'd4;
        if (BR_TAKEN) begin
            if (PC_MUX_SELECT == 3'd1) next_pc = {ALU_RESULT[31:1], 1'b0};
            else                       next_pc = pc_addr_q + IMM;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_addr_d  = pc_addr_q;
        mem_inst_d = mem_inst_q;
        err_d      = err_q;
        pend_d     = pend_q;
        wait_d     = wait_q;

        // One-deep overlap buffer: an edge arriving while busy is remembered.
        if (pc_edge && state_q != ST_IDLE && state_q != ST_HALT) pend_d = 1'b1;

        case (state_q)
            ST_BOOT: begin
                wait_d  = '0;
                state_d = ST_REQ;
            end
            ST_IDLE: begin
                if (pc_edge || pend_q) begin
                    pend_d = 1'b0;
                    if (next_pc[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        wait_d  = '0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Data on the last allowed cycle still wins over the timeout.
                if (IMEM_VALID) begin
                    mem_inst_d = IMEM_RDATA;
                    pc_addr_d  = pc_q;
                    state_d    = ST_ISSUE;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            ST_ISSUE: state_d = ST_IDLE;
            ST_HALT: begin
                err_d  = 1'b1;
                pend_d = 1'b0;
            end
            default: begin
                err_d   = 1'b1;
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST_DONE) begin
        if (RST_DONE) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            pc_addr_q  <= RESET_VECTOR;
            mem_inst_q <= NOP;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_addr_q  <= pc_addr_d;
            mem_inst_q <= mem_inst_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            wait_q     <= wait_d;
        end
    end

    // MEM_INST/PC_ADDR are loaded on entry to ISSUE, so they are new during
    // the strobe cycle itself.
    assign IMEM_ADDR = pc_q;
    assign IMEM_REQ  = (state_q == ST_REQ);
    assign INST_ENB  = (state_q == ST_ISSUE);
    assign MEM_INST  = mem_inst_q;
    assign PC_ADDR   = pc_addr_q;
    assign PC_PLUS4  = pc_addr_q + 32'd4;
    assign FETCH_ERR = err_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed stimulus against a reference model
// of the next-PC rules; expected fetch addresses go through exp_q.
module tb_fetch_unit;

    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        RST_DONE = 1'b1;
    logic        PC_CLK = 1'b0;
    logic [2:0]  PC_MUX_SELECT = '0;
    logic        BR_TAKEN = 1'b0;
    logic [31:0] IMM = '0;
    logic [31:0] ALU_RESULT = '0;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_REQ;
    logic [31:0] IMEM_RDATA = '0;
    logic        IMEM_VALID = 1'b0;
    logic [31:0] MEM_INST;
    logic        INST_ENB;
    logic [31:0] PC_ADDR;
    logic [31:0] PC_PLUS4;
    logic        FETCH_ERR;
    logic [2:0]  STATE_DBG;

    fetch_unit #(.RESET_VECTOR(32'h0), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST_DONE(RST_DONE), .PC_CLK(PC_CLK),
        .PC_MUX_SELECT(PC_MUX_SELECT), .BR_TAKEN(BR_TAKEN), .IMM(IMM),
        .ALU_RESULT(ALU_RESULT), .IMEM_ADDR(IMEM_ADDR), .IMEM_REQ(IMEM_REQ),
        .IMEM_RDATA(IMEM_RDATA), .IMEM_VALID(IMEM_VALID), .MEM_INST(MEM_INST),
        .INST_ENB(INST_ENB), .PC_ADDR(PC_ADDR), .PC_PLUS4(PC_PLUS4),
        .FETCH_ERR(FETCH_ERR), .STATE_DBG(STATE_DBG)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_pc;
    logic        prev_enb = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // The strobe may never be high on two consecutive cycles.
    always @(negedge CLK) begin
        if (prev_enb) check("enb_gap", {31'd0, INST_ENB}, 32'd0);
        prev_enb <= INST_ENB;
    end

    // reference model of the next-PC rules
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input bit br,
                                             input int sel, input logic [31:0] imm,
                                             input logic [31:0] alu);
        if (!br) return pc + 32'd4;
        if (sel == 1) return alu & 32'hFFFF_FFFE;
        return pc + imm;
    endfunction

    // drivers
    task automatic do_reset();
        RST_DONE   = 1'b1;
        IMEM_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_req",   {31'd0, IMEM_REQ}, 32'd0);
        check("rst_enb",   {31'd0, INST_ENB}, 32'd0);
        check("rst_err",   {31'd0, FETCH_ERR}, 32'd0);
        check("rst_inst",  MEM_INST, 32'h0000_0013);
        check("rst_pc",    PC_ADDR, 32'd0);
        check("rst_addr",  IMEM_ADDR, 32'd0);
        check("rst_plus4", PC_PLUS4, 32'd4);
        RST_DONE = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'd0);
        ref_pc = 32'd0;
    endtask

    task automatic set_br(input bit br, input int sel, input logic [31:0] imm,
                          input logic [31:0] alu);
        BR_TAKEN      = br;
        PC_MUX_SELECT = 3'(sel);
        IMM           = imm;
        ALU_RESULT    = alu;
        exp_q.push_back(ref_next(ref_pc, br, sel, imm, alu));
    endtask

    // One complete fetch: optional PC_CLK pulse, wait for the request, serve
    // it after wt wait cycles, check the issued word. exp_lat is the number of
    // cycles from pulse/entry to the first request cycle (0 = unchecked).
    task automatic run_fetch(input bit pulse, input int exp_lat, input int wt,
                             input bit pend_pulse, input string tag);
        logic [31:0] ea, w;
        int t;
        bit seen;
        ea = exp_q.pop_front();
        w  = $urandom;
        if (pulse) PC_CLK = 1'b1;
        t = 0;
        seen = 1'b0;
        while (!seen && t < 40) begin
            @(negedge CLK);
            t++;
            if (pulse && t == 2) PC_CLK = 1'b0;
            seen = IMEM_REQ;
        end
        PC_CLK = 1'b0;
        check({tag, "_req"}, {31'd0, seen}, 32'd1);
        if (!seen) return;
        if (exp_lat > 0) check({tag, "_lat"}, t, exp_lat);
        check({tag, "_addr"}, IMEM_ADDR, ea);
        for (int k = 0; k < wt; k++) begin
            if (pend_pulse && k == 0) PC_CLK = 1'b1;
            if (pend_pulse && k == 2) PC_CLK = 1'b0;
            @(negedge CLK);
            check({tag, "_hold"}, {31'd0, IMEM_REQ}, 32'd1);
        end
        PC_CLK     = 1'b0;
        IMEM_VALID = 1'b1;
        IMEM_RDATA = w;
        @(negedge CLK);
        IMEM_VALID = 1'b0;
        IMEM_RDATA = $urandom;
        check({tag, "_enb"},   {31'd0, INST_ENB}, 32'd1);
        check({tag, "_inst"},  MEM_INST, w);
        check({tag, "_pc"},    PC_ADDR, ea);
        check({tag, "_plus4"}, PC_PLUS4, ea + 32'd4);
        check({tag, "_err"},   {31'd0, FETCH_ERR}, 32'd0);
        @(negedge CLK);
        check({tag, "_enb0"},  {31'd0, INST_ENB}, 32'd0);
        ref_pc = ea;
    endtask

    // Watch n cycles and return whether any request appeared.
    task automatic watch_req(input int n, output bit any);
        any = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            if (IMEM_REQ) any = 1'b1;
        end
    endtask

    initial begin
        bit any;
        int n;
        int si;
        @(negedge CLK);

        // boot fetch, zero-wait memory
        do_reset();
        run_fetch(1'b0, 1, 0, 1'b0, "boot");

        // sequential fetches
        for (int i = 0; i < 3; i++) begin
            set_br(1'b0, 0, 32'd0, 32'd0);
            run_fetch(1'b1, 3, 0, 1'b0, "seq");
        end

        // directed targets
        set_br(1'b1, 1, 32'd0, 32'h0000_0100);
        run_fetch(1'b1, 3, 1, 1'b0, "jalr100");
        set_br(1'b1, 0, 32'hFFFF_FFF8, 32'd0);
        run_fetch(1'b1, 3, 0, 1'b0, "rel_m8");
        set_br(1'b1, 1, 32'd0, 32'h0000_0201);
        run_fetch(1'b1, 3, 2, 1'b0, "jalr201");
        set_br(1'b1, 5, 32'h0000_0010, 32'h0000_0801);
        run_fetch(1'b1, 3, 0, 1'b0, "sel5");
        set_br(1'b1, 1, 32'd0, 32'hFFFF_FFFC);
        run_fetch(1'b1, 3, 0, 1'b0, "to_top");
        set_br(1'b0, 0, 32'd0, 32'd0);
        run_fetch(1'b1, 3, 0, 1'b0, "wrap");

        // data on the last allowed wait cycle
        set_br(1'b0, 0, 32'd0, 32'd0);
        run_fetch(1'b1, 3, TO - 1, 1'b0, "late_ok");

        // edge during a wait is serviced right after the issue
        set_br(1'b0, 0, 32'd0, 32'd0);
        exp_q.push_back(ref_next(exp_q[0], 1'b0, 0, 32'd0, 32'd0));
        run_fetch(1'b1, 3, 5, 1'b1, "ovl_a");
        run_fetch(1'b0, 1, 0, 1'b0, "ovl_b");

        // randomized aligned traffic
        for (int i = 0; i < 25; i++) begin
            si = int'($urandom_range(0, 512));
            set_br(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   32'((si - 256) * 4), $urandom & 32'hFFFF_FFFD);
            run_fetch(1'b1, 3, int'($urandom_range(0, 3)), 1'b0, "rnd");
        end

        // misaligned target halts and ignores further edges
        BR_TAKEN = 1'b1; PC_MUX_SELECT = 3'd0; IMM = 32'd6;
        PC_CLK = 1'b1;
        repeat (2) @(negedge CLK);
        PC_CLK = 1'b0;
        watch_req(10, any);
        check("mis_noreq", {31'd0, any}, 32'd0);
        check("mis_err",   {31'd0, FETCH_ERR}, 32'd1);
        check("mis_pc",    PC_ADDR, ref_pc);
        check("mis_addr",  IMEM_ADDR, ref_pc);
        BR_TAKEN = 1'b0;
        PC_CLK = 1'b1;
        repeat (2) @(negedge CLK);
        PC_CLK = 1'b0;
        watch_req(10, any);
        check("halt_noreq", {31'd0, any}, 32'd0);
        check("halt_err",   {31'd0, FETCH_ERR}, 32'd1);
        check("halt_enb",   {31'd0, INST_ENB}, 32'd0);

        // PC_CLK already high at reset release is not an edge
        PC_CLK = 1'b1;
        do_reset();
        run_fetch(1'b0, 1, 0, 1'b0, "boot_hi");
        watch_req(8, any);
        check("hi_noreq", {31'd0, any}, 32'd0);
        PC_CLK = 1'b0;
        watch_req(4, any);
        check("fall_noreq", {31'd0, any}, 32'd0);
        set_br(1'b0, 0, 32'd0, 32'd0);
        run_fetch(1'b1, 3, 0, 1'b0, "after_hi");

        // reset in the middle of a fetch drops the request at once
        BR_TAKEN = 1'b0;
        PC_CLK = 1'b1;
        repeat (2) @(negedge CLK);
        PC_CLK = 1'b0;
        @(negedge CLK);
        check("mid_req", {31'd0, IMEM_REQ}, 32'd1);
        #2 RST_DONE = 1'b1;
        #1 check("mid_async", {31'd0, IMEM_REQ}, 32'd0);
        IMEM_VALID = 1'b1;
        @(negedge CLK);
        check("mid_enb", {31'd0, INST_ENB}, 32'd0);
        IMEM_VALID = 1'b0;
        do_reset();
        run_fetch(1'b0, 1, 0, 1'b0, "reboot");

        // memory never answers: fault after exactly TO request cycles
        BR_TAKEN = 1'b0;
        PC_CLK = 1'b1;
        repeat (2) @(negedge CLK);
        PC_CLK = 1'b0;
        @(negedge CLK);
        check("to_req", {31'd0, IMEM_REQ}, 32'd1);
        check("to_addr", IMEM_ADDR, ref_pc + 32'd4);
        n = 0;
        while (IMEM_REQ && n < 40) begin
            n++;
            @(negedge CLK);
        end
        check("to_cycles", n, TO);
        check("to_err", {31'd0, FETCH_ERR}, 32'd1);
        check("to_enb", {31'd0, INST_ENB}, 32'd0);
        watch_req(5, any);
        check("to_halt", {31'd0, any}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
